cdc_reset_receiver: RTL and testbench

CDC_RESET_RECEIVER -- requirements
Module: cdc_reset_receiver

---
 rtl/cdc_reset_receiver_pkg.sv | 13 +
 rtl/cdc_level_sync.sv | 23 ++
 rtl/cdc_reset_receiver.sv | 87 ++++++++
 tb/tb_cdc_reset_receiver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_reset_receiver_pkg.sv
// Shared types for the CDC reset receiver: FSM state encoding and pulse counter width.
package cdc_reset_receiver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

   // Wide enough for the largest legal pulse length (255).
   localparam int PCNT_W = 8;

endpackage

// File: rtl/cdc_level_sync.sv
// Multi-flop level synchronizer for a single asynchronous bit; output is the last stage.
module cdc_level_sync #(
   parameter int STAGES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_reset_receiver.sv
// Receives a 4-phase reset request from a foreign domain, emits a fixed-width
// synchronous reset pulse, then acknowledges until the request is withdrawn.
module cdc_reset_receiver
   import cdc_reset_receiver_pkg::*;
#(
   parameter int SYNC_STAGES = 3,
   parameter int PULSE_WIDTH = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_async,
   output logic             ack,
   output logic             rst_pulse_out,
   output logic             busy,
   output logic [CNT_W-1:0] req_count,
   input  logic             err_clr,
   output logic             proto_err,
   output state_t           state_dbg
);

   // Handshake: req_async/ack is a 4-phase level pair. ack rises after the pulse,
   // stays high while req is seen high, and drops one cycle after req_s is seen low.
   localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_WIDTH - 1);

   state_t            state;
   logic [PCNT_W-1:0] pulse_cnt;
   logic              req_s;
   logic              err_set;

   cdc_level_sync #(
      .STAGES (SYNC_STAGES)
   ) u_req_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req_async),
      .q     (req_s)
   );

   // Withdrawn before ack is visible: during the pulse, or on the first ACK cycle.
   assign err_set = !req_s && ((state == ST_PULSE) || ((state == ST_ACK) && !ack));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         pulse_cnt     <= '0;
         ack           <= 1'b0;
         rst_pulse_out <= 1'b0;
         req_count     <= '0;
         proto_err     <= 1'b0;
      end else begin
         rst_pulse_out <= (state == ST_PULSE);
         ack           <= (state == ST_ACK);
         if (err_set) begin
            proto_err <= 1'b1;
         end else if (err_clr) begin
            proto_err <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (req_s) begin
                  state     <= ST_PULSE;
                  pulse_cnt <= PULSE_LOAD;
                  req_count <= req_count + 1'b1;
               end
            end
            ST_PULSE: begin
               if (pulse_cnt == '0) begin
                  state <= ST_ACK;
               end else begin
                  pulse_cnt <= pulse_cnt - 1'b1;
               end
            end
            ST_ACK: begin
               if (!req_s) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_cdc_reset_receiver.sv
// Directed bench for cdc_reset_receiver: cycle tables plus reset, hold and wrap sequences.
module tb_cdc_reset_receiver;
   import cdc_reset_receiver_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       req_async;
   logic       err_clr;
   logic       ack;
   logic       rst_pulse_out;
   logic       busy;
   logic [7:0] req_count;
   logic       proto_err;
   state_t     state_dbg;

   logic       req2;
   logic       ack2;
   logic       pulse2;
   logic       busy2;
   logic [1:0] cnt2;
   logic       err2;
   state_t     state2;

   int n_pass;
   int n_total;

   typedef struct {
      logic       req;
      logic       clr;
      logic       pulse;
      logic       ack;
      logic       busy;
      logic       err;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[$];

   cdc_reset_receiver dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_async     (req_async),
      .ack           (ack),
      .rst_pulse_out (rst_pulse_out),
      .busy          (busy),
      .req_count     (req_count),
      .err_clr       (err_clr),
      .proto_err     (proto_err),
      .state_dbg     (state_dbg)
   );

   cdc_reset_receiver #(
      .SYNC_STAGES (2),
      .PULSE_WIDTH (1),
      .CNT_W       (2)
   ) dut2 (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_async     (req2),
      .ack           (ack2),
      .rst_pulse_out (pulse2),
      .busy          (busy2),
      .req_count     (cnt2),
      .err_clr       (1'b0),
      .proto_err     (err2),
      .state_dbg     (state2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic run(input int n, input logic rq, input logic cl, input logic p,
                      input logic a, input logic b, input logic e, input logic [7:0] c);
      vec_t v;
      v.req = rq; v.clr = cl; v.pulse = p; v.ack = a; v.busy = b; v.err = e; v.cnt = c;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic hs2(input logic [1:0] exp_cnt, input int idx);
      int n;
      int w;
      @(negedge clk);
      req2 = 1'b1;
      n = 0;
      @(posedge clk); #1;
      while (!pulse2 && n < 30) begin
         n++;
         @(posedge clk); #1;
      end
      chk($sformatf("dut2_latency_%0d", idx), n, 3);
      w = 0;
      while (pulse2 && w < 30) begin
         @(posedge clk); #1;
         w++;
      end
      chk($sformatf("dut2_width_%0d", idx), w, 1);
      chk($sformatf("dut2_ack_%0d", idx), ack2, 1'b1);
      chk($sformatf("dut2_cnt_%0d", idx), cnt2, exp_cnt);
      @(negedge clk);
      req2 = 1'b0;
      n = 0;
      while (ack2 && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("dut2_ack_drop_%0d", idx), ack2, 1'b0);
   endtask

   initial begin
      int rises;
      int highs;
      int both;
      int n;
      logic prev;

      n_pass = 0;
      n_total = 0;
      rst_n = 1'b0;
      req_async = 1'b0;
      err_clr = 1'b0;
      req2 = 1'b0;

      // Sequence A: handshake, release, second handshake.
      run(3, 1, 0, 0, 0, 0, 0, 1'd0 + 8'd0);
      run(1, 1, 0, 0, 0, 1, 0, 8'd1);
      run(4, 1, 0, 1, 0, 1, 0, 8'd1);
      run(2, 1, 0, 0, 1, 1, 0, 8'd1);
      run(3, 0, 0, 0, 1, 1, 0, 8'd1);
      run(1, 0, 0, 0, 1, 0, 0, 8'd1);
      run(2, 0, 0, 0, 0, 0, 0, 8'd1);
      run(3, 1, 0, 0, 0, 0, 0, 8'd1);
      run(1, 1, 0, 0, 0, 1, 0, 8'd2);
      run(4, 1, 0, 1, 0, 1, 0, 8'd2);
      run(1, 1, 0, 0, 1, 1, 0, 8'd2);
      run(3, 0, 0, 0, 1, 1, 0, 8'd2);
      run(1, 0, 0, 0, 1, 0, 0, 8'd2);
      run(2, 0, 0, 0, 0, 0, 0, 8'd2);
      // Sequence B: request dropped inside the pulse, then cleared.
      run(3, 1, 0, 0, 0, 0, 0, 8'd2);
      run(1, 1, 0, 0, 0, 1, 0, 8'd3);
      run(1, 1, 0, 1, 0, 1, 0, 8'd3);
      run(3, 0, 0, 1, 0, 1, 0, 8'd3);
      run(1, 0, 0, 0, 1, 0, 1, 8'd3);
      run(1, 0, 0, 0, 0, 0, 1, 8'd3);
      run(1, 0, 1, 0, 0, 0, 0, 8'd3);
      run(1, 0, 0, 0, 0, 0, 0, 8'd3);
      // Sequence C: clear asserted on the same cycle as the error set.
      run(3, 1, 0, 0, 0, 0, 0, 8'd3);
      run(1, 1, 0, 0, 0, 1, 0, 8'd4);
      run(1, 1, 0, 1, 0, 1, 0, 8'd4);
      run(3, 0, 0, 1, 0, 1, 0, 8'd4);
      run(1, 0, 1, 0, 1, 0, 1, 8'd4);
      run(1, 0, 1, 0, 0, 0, 0, 8'd4);
      run(1, 0, 0, 0, 0, 0, 0, 8'd4);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pulse", rst_pulse_out, 1'b0);
      chk("rst_ack", ack, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cnt", req_count, 8'd0);
      chk("rst_err", proto_err, 1'b0);
      chk("rst_cnt2", cnt2, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         req_async = vecs[i].req;
         err_clr = vecs[i].clr;
         @(posedge clk); #1;
         chk($sformatf("vec%0d_pulse", i), rst_pulse_out, vecs[i].pulse);
         chk($sformatf("vec%0d_ack", i), ack, vecs[i].ack);
         chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
         chk($sformatf("vec%0d_err", i), proto_err, vecs[i].err);
         chk($sformatf("vec%0d_cnt", i), req_count, vecs[i].cnt);
      end
      @(negedge clk);
      err_clr = 1'b0;

      // Request held high for 100 cycles: one pulse only.
      req_async = 1'b1;
      rises = 0; highs = 0; both = 0; prev = 1'b0;
      repeat (100) begin
         @(posedge clk); #1;
         if (rst_pulse_out) highs++;
         if (rst_pulse_out && !prev) rises++;
         if (rst_pulse_out && ack) both++;
         prev = rst_pulse_out;
      end
      chk("hold_rises", rises, 1);
      chk("hold_width", highs, 4);
      chk("hold_overlap", both, 0);
      chk("hold_ack", ack, 1'b1);
      chk("hold_cnt", req_count, 8'd5);
      @(negedge clk);
      req_async = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("hold_ack_still", ack, 1'b1);
      @(posedge clk); #1;
      chk("hold_ack_fall", ack, 1'b0);

      // Reset during the second pulse cycle, request still high at release.
      @(negedge clk);
      req_async = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_pulse_pre", rst_pulse_out, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_pulse", rst_pulse_out, 1'b0);
      chk("midrst_ack", ack, 1'b0);
      chk("midrst_cnt", req_count, 8'd0);
      chk("midrst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("midrst_relat_%0d", k), rst_pulse_out, (k == 4));
      end
      chk("midrst_cnt_after", req_count, 8'd1);
      n = 0;
      while (!ack && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("midrst_ack_timeout", ack, 1'b1);
      @(negedge clk);
      req_async = 1'b0;
      n = 0;
      while (ack && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("midrst_ack_drop", ack, 1'b0);

      // Narrow counter wrap with short sync chain and single-cycle pulse.
      hs2(2'd1, 0);
      hs2(2'd2, 1);
      hs2(2'd3, 2);
      hs2(2'd0, 3);
      hs2(2'd1, 4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
